// File: rtl/serial_sub_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : serial_sub_pkg
//  Description : State encoding and counter-width helper for serial_subtractor.
//  Revision    : 1.0 - initial release
// ============================================================================
package serial_sub_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    // Bit-counter width for an n-bit operand; never narrower than one bit.
    function automatic int cnt_width(input int n);
        return (n < 2) ? 1 : $clog2(n);
    endfunction

endpackage
`default_nettype wire

// File: rtl/full_subtractor.sv
`default_nettype none
// ============================================================================
//  Module      : full_subtractor
//  Description : Single-bit combinational subtract cell, d = a - b - bi.
//  Revision    : 1.0 - initial release
// ============================================================================
module full_subtractor (
    input  logic a,
    input  logic b,
    input  logic bi,
    output logic d,
    output logic bo
);

    assign d  = a ^ b ^ bi;
    assign bo = (~a & b) | (~(a ^ b) & bi);

endmodule
`default_nettype wire

// File: rtl/serial_subtractor.sv
`default_nettype none
// ============================================================================
//  Module      : serial_subtractor
//  Description : Bit-serial N-bit subtractor (in0 - in1 - bin), LSB first,
//                start/done handshake. Define SERIAL_SUB_OVF_EN to add ovf.
//  Revision    : 1.0 - initial release
// ============================================================================
module serial_subtractor
    import serial_sub_pkg::*;
#(
    parameter int N = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic [N-1:0] in0,
    input  logic [N-1:0] in1,
    input  logic         bin,
    output logic         busy,
    output logic         done,
    output logic [N-1:0] diff,
    output logic         bout
`ifdef SERIAL_SUB_OVF_EN
    ,
    output logic         ovf
`endif
);

    localparam int              c_cnt_w    = cnt_width(N);
    localparam logic [c_cnt_w-1:0] c_cnt_last = c_cnt_w'(N - 1);

    state_t             r_state;
    logic [N-1:0]       r_a;
    logic [N-1:0]       r_b;
    logic [N-2:0]       r_part;
    logic               r_br;
    logic [c_cnt_w-1:0] r_cnt;

    logic               w_d;
    logic               w_bo;
    logic [N-1:0]       w_cat;

    full_subtractor u_cell (
        .a  (r_a[0]),
        .b  (r_b[0]),
        .bi (r_br),
        .d  (w_d),
        .bo (w_bo)
    );

    // Partial result holds the N-1 bits already produced; the current bit
    // completes the word on the final cycle.
    assign w_cat = {w_d, r_part};

`ifdef SERIAL_SUB_OVF_EN
    logic w_ovf;
    // On the final bit r_a[0]/r_b[0] are the captured sign bits.
    assign w_ovf = (r_a[0] ^ r_b[0]) & (w_d ^ r_a[0]);
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
            r_a     <= '0;
            r_b     <= '0;
            r_part  <= '0;
            r_br    <= 1'b0;
            r_cnt   <= '0;
            busy    <= 1'b0;
            done    <= 1'b0;
            diff    <= '0;
            bout    <= 1'b0;
`ifdef SERIAL_SUB_OVF_EN
            ovf     <= 1'b0;
`endif
        end else begin
            case (r_state)
                ST_IDLE: begin
                    done <= 1'b0;
                    if (start) begin
                        r_a     <= in0;
                        r_b     <= in1;
                        r_br    <= bin;
                        r_cnt   <= '0;
                        busy    <= 1'b1;
                        r_state <= ST_RUN;
                    end
                end
                ST_RUN: begin
                    r_a    <= r_a >> 1;
                    r_b    <= r_b >> 1;
                    r_br   <= w_bo;
                    r_part <= w_cat[N-1:1];
                    r_cnt  <= r_cnt + 1'b1;
                    if (r_cnt == c_cnt_last) begin
                        diff    <= w_cat;
                        bout    <= w_bo;
`ifdef SERIAL_SUB_OVF_EN
                        ovf     <= w_ovf;
`endif
                        busy    <= 1'b0;
                        done    <= 1'b1;
                        r_state <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    done    <= 1'b0;
                    r_state <= ST_IDLE;
                end
                default: begin
                    busy    <= 1'b0;
                    done    <= 1'b0;
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule
`default_nettype wire
